// File: rtl/ahb_rom_ws.sv
// AHB-Lite read-only memory slave with pipelined address/data phases,
// programmable wait states and a two-cycle ERROR response for rejected accesses.
module ahb_rom_ws #(
    parameter int          DATA_W      = 32,
    parameter int          DEPTH       = 8192,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 0,
    parameter              INIT_FILE   = ""
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              HSEL,
    input  logic [31:0]       HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [2:0]        HBURST,
    input  logic [3:0]        HPROT,
    input  logic [DATA_W-1:0] HWDATA,
    input  logic              HREADY,
    output logic [DATA_W-1:0] HRDATA,
    output logic              HREADYOUT,
    output logic              HRESP
);

    localparam int          BYTES = DATA_W / 8;
    localparam int          LSB   = $clog2(BYTES);
    localparam int          AW    = $clog2(DEPTH);
    localparam logic [63:0] SPAN  = 64'(DEPTH) * 64'(BYTES);
    localparam logic [3:0]  WS    = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_t;

    logic [DATA_W-1:0] rom_r [DEPTH];

    state_t            state_r, state_s;
    logic              readyout_r, readyout_s;
    logic              resp_r, resp_s;
    logic [3:0]        cnt_r, cnt_s;
    logic [AW-1:0]     idx_r, idx_s;
    logic [DATA_W-1:0] rdata_r;
    logic              load_s;
    logic [AW-1:0]     load_idx_s;
    logic              accept_s;
    logic [AW-1:0]     addr_idx_s;
    logic              unused_s;

    // Rejects writes, oversize, misaligned and out-of-window accesses, in that order.
    function automatic logic is_error(input logic write, input logic [2:0] size,
                                      input logic [31:0] addr);
        logic [31:0] mask;
        logic [32:0] diff;
        mask = (32'd1 << size) - 32'd1;
        diff = {1'b0, addr} - {1'b0, BASE_ADDR};
        is_error = write || (size > 3'(LSB)) || ((addr & mask) != 32'd0) ||
                   diff[32] || ({32'd0, diff[31:0]} >= SPAN);
    endfunction

    assign accept_s   = HSEL & HREADY & HTRANS[1];
    assign addr_idx_s = AW'((HADDR - BASE_ADDR) >> LSB);
    assign unused_s   = ^{HBURST, HPROT, HWDATA, HTRANS[0]};

    // Next-state and next-output decode for the data-phase FSM.
    always_comb begin
        state_s    = state_r;
        readyout_s = readyout_r;
        resp_s     = resp_r;
        cnt_s      = cnt_r;
        idx_s      = idx_r;
        load_s     = 1'b0;
        load_idx_s = idx_r;
        case (state_r)
            ST_IDLE, ST_ERR2: begin
                if (accept_s && is_error(HWRITE, HSIZE, HADDR)) begin
                    readyout_s = 1'b0;
                    resp_s     = 1'b1;
                    state_s    = ST_ERR1;
                end else if (accept_s && (WAIT_STATES == 0)) begin
                    load_s     = 1'b1;
                    load_idx_s = addr_idx_s;
                    readyout_s = 1'b1;
                    resp_s     = 1'b0;
                    state_s    = ST_IDLE;
                end else if (accept_s) begin
                    readyout_s = 1'b0;
                    resp_s     = 1'b0;
                    cnt_s      = WS;
                    idx_s      = addr_idx_s;
                    state_s    = ST_WAIT;
                end else begin
                    readyout_s = 1'b1;
                    resp_s     = 1'b0;
                    state_s    = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // The word is fetched on the last low cycle so it lands with HREADYOUT.
                if (cnt_r == 4'd1) begin
                    load_s     = 1'b1;
                    readyout_s = 1'b1;
                    cnt_s      = 4'd0;
                    state_s    = ST_IDLE;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            ST_ERR1: begin
                readyout_s = 1'b1;
                resp_s     = 1'b1;
                state_s    = ST_ERR2;
            end
            default: begin
                readyout_s = 1'b1;
                resp_s     = 1'b0;
                state_s    = ST_IDLE;
            end
        endcase
    end

    // FSM state and handshake registers.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_r    <= ST_IDLE;
            readyout_r <= 1'b1;
            resp_r     <= 1'b0;
            cnt_r      <= 4'd0;
            idx_r      <= {AW{1'b0}};
        end else begin
            state_r    <= state_s;
            readyout_r <= readyout_s;
            resp_r     <= resp_s;
            cnt_r      <= cnt_s;
            idx_r      <= idx_s;
        end
    end

    // Read-data register; holds its value between reads.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            rdata_r <= {DATA_W{1'b0}};
        end else if (load_s) begin
            rdata_r <= rom_r[load_idx_s];
        end else begin
            rdata_r <= rdata_r;
        end
    end

    assign HRDATA    = rdata_r;
    assign HREADYOUT = readyout_r;
    assign HRESP     = resp_r;

endmodule

// File: tb/tb_ahb_rom_ws.sv
// Scoreboard bench for ahb_rom_ws: three instances (32b/WS0, 32b/WS3, 64b/WS0)
// share one address bus; a negedge monitor checks each data phase against a queue.
module tb_ahb_rom_ws;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    int          sel;

    logic [31:0] rd_a, rd_b;
    logic [63:0] rd_c;
    logic        rdy_a, rdy_b, rdy_c, rsp_a, rsp_b, rsp_c;
    logic [63:0] rd_m;
    logic        rdy_m, rsp_m;

    always #5 clk = ~clk;

    ahb_rom_ws #(.DATA_W(32), .DEPTH(8192), .WAIT_STATES(0)) u_a (
        .HCLK(clk), .HRESET(rst), .HSEL(hsel && (sel == 0)), .HADDR(haddr),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'd0),
        .HPROT(4'd0), .HWDATA(32'd0), .HREADY(rdy_a),
        .HRDATA(rd_a), .HREADYOUT(rdy_a), .HRESP(rsp_a));

    ahb_rom_ws #(.DATA_W(32), .DEPTH(8192), .WAIT_STATES(3)) u_b (
        .HCLK(clk), .HRESET(rst), .HSEL(hsel && (sel == 1)), .HADDR(haddr),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'd0),
        .HPROT(4'd0), .HWDATA(32'd0), .HREADY(rdy_b),
        .HRDATA(rd_b), .HREADYOUT(rdy_b), .HRESP(rsp_b));

    ahb_rom_ws #(.DATA_W(64), .DEPTH(16), .WAIT_STATES(0)) u_c (
        .HCLK(clk), .HRESET(rst), .HSEL(hsel && (sel == 2)), .HADDR(haddr),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'd0),
        .HPROT(4'd0), .HWDATA(64'd0), .HREADY(rdy_c),
        .HRDATA(rd_c), .HREADYOUT(rdy_c), .HRESP(rsp_c));

    always_comb begin
        case (sel)
            0:       begin rd_m = {32'd0, rd_a}; rdy_m = rdy_a; rsp_m = rsp_a; end
            1:       begin rd_m = {32'd0, rd_b}; rdy_m = rdy_b; rsp_m = rsp_b; end
            default: begin rd_m = rd_c;          rdy_m = rdy_c; rsp_m = rsp_c; end
        endcase
    end

    typedef struct {
        logic [63:0] data;
        logic        resp;
        int          low;
        logic [31:0] addr;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_miss = 0;
    int          low_cnt = 0;
    bit          mon_en = 1'b0;
    logic [63:0] last [3];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: one check per data-phase cycle, or idle-bus checks when nothing is pending.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (sb.size() > 0) begin
                if (!rdy_m) begin
                    low_cnt++;
                    chk($sformatf("resp_low@%h", sb[0].addr), 64'(rsp_m), 64'(sb[0].resp));
                end else begin
                    chk($sformatf("resp@%h", sb[0].addr), 64'(rsp_m), 64'(sb[0].resp));
                    chk($sformatf("low_cycles@%h", sb[0].addr), 64'(low_cnt), 64'(sb[0].low));
                    if (!sb[0].resp) begin
                        chk($sformatf("rdata@%h", sb[0].addr), rd_m, sb[0].data);
                        last[sel] = sb[0].data;
                    end
                    low_cnt = 0;
                    void'(sb.pop_front());
                end
            end else begin
                chk("idle_ready", 64'(rdy_m), 64'd1);
                chk("idle_resp", 64'(rsp_m), 64'd0);
                chk("idle_hold", rd_m, last[sel]);
            end
        end
    end

    task automatic xfer(input logic [31:0] a, input logic [1:0] tr, input logic w,
                        input logic [2:0] sz, input logic [63:0] d, input logic r,
                        input int low);
        exp_t e;
        int   n = 0;
        hsel = 1'b1; haddr = a; htrans = tr; hwrite = w; hsize = sz;
        while (!rdy_m && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!rdy_m) begin
            n_vec++;
            n_miss++;
            $display("FAIL accept_timeout: addr %h still waiting, required HREADYOUT=1", a);
        end
        @(posedge clk);
        #1;
        e.data = d; e.resp = r; e.low = low; e.addr = a;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain_timeout: %0d pending, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic set_sel(input int s);
        idle(2);
        drain();
        @(posedge clk);
        sel = s;
        @(negedge clk);
    endtask

    initial begin
        hsel = 1'b0; haddr = 32'd0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd2; sel = 0;
        last[0] = 64'd0; last[1] = 64'd0; last[2] = 64'd0;
        u_a.rom_r[0]    = 32'h0000_0011;
        u_a.rom_r[1]    = 32'h0000_0022;
        u_a.rom_r[2]    = 32'h0000_0033;
        u_a.rom_r[8191] = 32'h7FFC_BEEF;
        u_b.rom_r[4]    = 32'hCAFE_0004;
        u_b.rom_r[5]    = 32'hCAFE_0005;
        u_c.rom_r[0]    = 64'hFEDC_BA98_7654_3210;
        u_c.rom_r[1]    = 64'h0123_4567_89AB_CDEF;
        u_c.rom_r[15]   = 64'h0F0F_1E1E_2D2D_3C3C;
        repeat (2) @(negedge clk);

        chk("rst_rdy_a", 64'(rdy_a), 64'd1); chk("rst_rsp_a", 64'(rsp_a), 64'd0); chk("rst_rd_a", 64'(rd_a), 64'd0);
        chk("rst_rdy_b", 64'(rdy_b), 64'd1); chk("rst_rsp_b", 64'(rsp_b), 64'd0); chk("rst_rd_b", 64'(rd_b), 64'd0);
        chk("rst_rdy_c", 64'(rdy_c), 64'd1); chk("rst_rsp_c", 64'(rsp_c), 64'd0); chk("rst_rd_c", rd_c, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;

        // 32-bit, zero wait states
        xfer(32'h0000_0000, 2'b10, 1'b0, 3'd2, 64'h11, 1'b0, 0);
        xfer(32'h0000_0004, 2'b11, 1'b0, 3'd2, 64'h22, 1'b0, 0);
        xfer(32'h0000_0008, 2'b11, 1'b0, 3'd2, 64'h33, 1'b0, 0);
        idle(2);
        xfer(32'h0000_0000, 2'b10, 1'b1, 3'd2, 64'h0, 1'b1, 1);
        idle(3);
        xfer(32'h0000_7FFC, 2'b10, 1'b0, 3'd2, 64'h7FFC_BEEF, 1'b0, 0);
        xfer(32'h0000_8000, 2'b10, 1'b0, 3'd2, 64'h0, 1'b1, 1);
        xfer(32'h0000_0002, 2'b10, 1'b0, 3'd2, 64'h0, 1'b1, 1);
        xfer(32'h0000_0000, 2'b10, 1'b0, 3'd3, 64'h0, 1'b1, 1);
        xfer(32'h0000_0004, 2'b11, 1'b0, 3'd2, 64'h22, 1'b0, 0);
        xfer(32'h0000_0003, 2'b10, 1'b0, 3'd0, 64'h11, 1'b0, 0);
        idle(2);

        // 32-bit, three wait states
        set_sel(1);
        xfer(32'h0000_0010, 2'b10, 1'b0, 3'd2, 64'hCAFE_0004, 1'b0, 3);
        xfer(32'h0000_0014, 2'b11, 1'b0, 3'd2, 64'hCAFE_0005, 1'b0, 3);
        idle(2);
        xfer(32'h0000_0010, 2'b10, 1'b1, 3'd2, 64'h0, 1'b1, 1);
        idle(3);

        // 64-bit
        set_sel(2);
        xfer(32'h0000_0008, 2'b10, 1'b0, 3'd3, 64'h0123_4567_89AB_CDEF, 1'b0, 0);
        idle(1);
        hsel = 1'b1; haddr = 32'h0000_0000; htrans = 2'b01; hsize = 3'd3;
        repeat (3) @(negedge clk);
        hsel = 1'b0; htrans = 2'b10;
        repeat (3) @(negedge clk);
        xfer(32'h0000_0004, 2'b10, 1'b0, 3'd2, 64'hFEDC_BA98_7654_3210, 1'b0, 0);
        xfer(32'h0000_0004, 2'b10, 1'b0, 3'd3, 64'h0, 1'b1, 1);
        xfer(32'h0000_0078, 2'b10, 1'b0, 3'd3, 64'h0F0F_1E1E_2D2D_3C3C, 1'b0, 0);
        xfer(32'h0000_0080, 2'b10, 1'b0, 3'd3, 64'h0, 1'b1, 1);
        idle(3);

        // Reset in the middle of a wait-state read
        set_sel(1);
        mon_en = 1'b0;
        hsel = 1'b1; haddr = 32'h0000_0010; htrans = 2'b10; hwrite = 1'b0; hsize = 3'd2;
        @(posedge clk);
        #1;
        hsel = 1'b0; htrans = 2'b00;
        repeat (2) @(negedge clk);
        chk("mid_wait_rdy", 64'(rdy_b), 64'd0);
        rst = 1'b1;
        #1;
        chk("rst_wait_rdy", 64'(rdy_b), 64'd1);
        chk("rst_wait_rsp", 64'(rsp_b), 64'd0);
        chk("rst_wait_rd", 64'(rd_b), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
